// File: rtl/font_rom_arbiter.sv
// Two-requester arbiter for a shared synchronous digit-font ROM, with a tag pipeline
// that returns each font line to the requester that asked. Optional macro: FONT_ARB_RR_EN.
module font_rom_arbiter #(
   parameter int ROM_LAT = 1,
   parameter int CODE_W  = 4,
   parameter int LINE_W  = 4,
   parameter int DATA_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               req,
   input  logic [CODE_W-1:0]        code0,
   input  logic [LINE_W-1:0]        line0,
   input  logic [CODE_W-1:0]        code1,
   input  logic [LINE_W-1:0]        line1,
   output logic [1:0]               gnt,
   output logic                     rom_en,
   output logic [CODE_W+LINE_W-1:0] rom_addr,
   input  logic [DATA_W-1:0]        rom_data,
   output logic [1:0]               rvalid,
   output logic [DATA_W-1:0]        rdata
);

   // Handshake: req stays high until the matching one-cycle gnt pulse; results come
   // back as a one-cycle rvalid pulse with no back-pressure, in grant order.

   logic [1:0]        elig;
   logic [1:0]        win;
   logic              win_id;
   logic [CODE_W-1:0] win_code;
   logic [LINE_W-1:0] win_line;
   logic              win_blank;

   // The registered gnt masks its own requester so a held req is not granted twice.
   assign elig = req & ~gnt;

`ifdef FONT_ARB_RR_EN
   logic last_q;

   always_comb begin
      win = elig;
      if (elig == 2'b11)
         win = last_q ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_q <= 1'b1;
      else if (|win)
         last_q <= win[1];
   end
`else
   always_comb begin
      win = {elig[1] & ~elig[0], elig[0]};
   end
`endif

   assign win_id    = win[1];
   assign win_code  = win_id ? code1 : code0;
   assign win_line  = win_id ? line1 : line0;
   assign win_blank = (win_code > CODE_W'(9));

   // Tag stage k describes the grant issued k cycles ago.
   logic [ROM_LAT:0] tag_v;
   logic [ROM_LAT:0] tag_id;
   logic [ROM_LAT:0] tag_blank;

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt       <= 2'b00;
         rom_en    <= 1'b0;
         rom_addr  <= '0;
         tag_v     <= '0;
         tag_id    <= '0;
         tag_blank <= '0;
         rvalid    <= 2'b00;
         rdata     <= '0;
      end else begin
         gnt    <= win;
         rom_en <= (|win) & ~win_blank;
         if (|win)
            rom_addr <= {win_code, win_line};
         tag_v     <= {tag_v[ROM_LAT-1:0],     |win};
         tag_id    <= {tag_id[ROM_LAT-1:0],    win_id};
         tag_blank <= {tag_blank[ROM_LAT-1:0], win_blank};
         rvalid    <= tag_v[ROM_LAT] ? {tag_id[ROM_LAT], ~tag_id[ROM_LAT]} : 2'b00;
         if (tag_v[ROM_LAT])
            rdata <= tag_blank[ROM_LAT] ? '0 : rom_data;
      end
   end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Self-checking bench for font_rom_arbiter: directed scenarios plus random traffic
// against a grant/return reference model and a behavioural latency ROM.
module tb_font_rom_arbiter;

   localparam int ROM_LAT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic [3:0] code0 = 4'd0, code1 = 4'd0;
   logic [3:0] line0 = 4'd0, line1 = 4'd0;
   logic [1:0] gnt;
   logic       rom_en;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic [1:0] rvalid;
   logic [7:0] rdata;

   font_rom_arbiter #(.ROM_LAT(ROM_LAT), .CODE_W(4), .LINE_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .req(req),
      .code0(code0), .line0(line0), .code1(code1), .line1(line1),
      .gnt(gnt), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .rvalid(rvalid), .rdata(rdata)
   );

   always #5 clk = ~clk;

   // Font ROM: data appears ROM_LAT cycles after an enabled address; noise otherwise.
   logic [7:0] rom_mem [256];
   logic [7:0] rd_pipe [ROM_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= rom_en ? rom_mem[rom_addr] : 8'($urandom);
      for (int k = 1; k < ROM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign rom_data = rd_pipe[ROM_LAT-1];

   typedef struct {
      int         due;
      logic [1:0] id_oh;
      logic [7:0] data;
   } ret_t;

   ret_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [1:0] m_gnt = 2'b00;
   logic       m_last = 1'b1;
   logic [7:0] m_addr = 8'h00;
   logic       m_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: predict the grant from the inputs present at the edge, then check.
   task automatic tick();
      logic [1:0] pend, w;
      logic [3:0] c, l;
      logic       was_rst;
      logic [1:0] e_rv;
      logic [7:0] e_rd;
      was_rst = rst;
      pend = req & ~m_gnt;
      if (pend == 2'b11) begin
`ifdef FONT_ARB_RR_EN
         w = (m_last == 1'b1) ? 2'b01 : 2'b10;
`else
         w = 2'b01;
`endif
      end else begin
         w = pend;
      end
      c = w[1] ? code1 : code0;
      l = w[1] ? line1 : line0;
      @(posedge clk);
      #1;
      cyc++;
      if (was_rst) begin
         m_gnt = 2'b00; m_last = 1'b1; m_addr = 8'h00; m_en = 1'b0;
         exp_q.delete();
         chk("rst_gnt", 32'(gnt), 32'h0);
         chk("rst_rom_en", 32'(rom_en), 32'h0);
         chk("rst_rom_addr", 32'(rom_addr), 32'h0);
         chk("rst_rvalid", 32'(rvalid), 32'h0);
         chk("rst_rdata", 32'(rdata), 32'h0);
         return;
      end
      m_gnt = w;
      m_en = 1'b0;
      if (w != 2'b00) begin
         m_addr = {c, l};
         m_en = (c <= 4'd9);
         m_last = w[1];
         exp_q.push_back('{cyc + ROM_LAT + 1, w, (c <= 4'd9) ? rom_mem[{c, l}] : 8'h00});
      end
      e_rv = 2'b00;
      e_rd = 8'h00;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
         e_rv = exp_q[0].id_oh;
         e_rd = exp_q[0].data;
         void'(exp_q.pop_front());
      end
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("rom_en", 32'(rom_en), 32'(m_en));
      chk("rom_addr", 32'(rom_addr), 32'(m_addr));
      chk("rvalid", 32'(rvalid), 32'(e_rv));
      if (e_rv != 2'b00) chk("rdata", 32'(rdata), 32'(e_rd));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [1:0] seq [4];
      int         n_g;
      logic       prev_g;
      for (int a = 0; a < 256; a++) rom_mem[a] = 8'($urandom_range(1, 255));
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;

      // Reset and reset values
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      idle(2);

      // Single request from the board drawer
      req = 2'b01; code0 = 4'd3; line0 = 4'd5;
      tick();
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_addr", 32'(rom_addr), 32'h35);
      chk("t1_en", 32'(rom_en), 32'h1);
      req = 2'b00;
      idle(ROM_LAT + 2);

      // Both held, new codes after each grant; start from a fresh pointer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 2'b11;
      code0 = 4'($urandom_range(0, 9)); line0 = 4'($urandom);
      code1 = 4'($urandom_range(0, 9)); line1 = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_seq", 32'(gnt), 32'(seq[i]));
         if (gnt[0]) begin code0 = 4'($urandom_range(0, 9)); line0 = 4'($urandom); end
         if (gnt[1]) begin code1 = 4'($urandom_range(0, 9)); line1 = 4'($urandom); end
      end
      req = 2'b00;
      idle(ROM_LAT + 3);

      // Blank code from the counter display
      req = 2'b10; code1 = 4'hF; line1 = 4'd7;
      tick();
      chk("t4_gnt", 32'(gnt), 32'h2);
      chk("t4_en", 32'(rom_en), 32'h0);
      req = 2'b00;
      idle(ROM_LAT + 2);

      // One requester held for six cycles with the same code
      req = 2'b01; code0 = 4'd8; line0 = 4'd2;
      n_g = 0;
      prev_g = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (gnt[0] && prev_g) chk("t6_back_to_back", 32'h1, 32'h0);
         prev_g = gnt[0];
         if (gnt[0]) n_g++;
      end
      chk("t6_count", 32'(n_g), 32'd3);
      req = 2'b00;
      idle(ROM_LAT + 3);

      // Reset one cycle after a grant: the return must be dropped
      req = 2'b01; code0 = 4'd6; line0 = 4'd1;
      tick();
      chk("t5_gnt", 32'(gnt), 32'h1);
      req = 2'b00;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < ROM_LAT + 3; i++) begin
         tick();
         chk("t5_no_rvalid", 32'(rvalid), 32'h0);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         tick();
         if (req[0] && m_gnt[0]) begin
            if ($urandom_range(0, 1) == 0) req[0] = 1'b0;
            code0 = 4'($urandom_range(0, 15)); line0 = 4'($urandom);
         end else if (!req[0] && $urandom_range(0, 2) == 0) begin
            req[0] = 1'b1; code0 = 4'($urandom_range(0, 15)); line0 = 4'($urandom);
         end
         if (req[1] && m_gnt[1]) begin
            if ($urandom_range(0, 1) == 0) req[1] = 1'b0;
            code1 = 4'($urandom_range(0, 15)); line1 = 4'($urandom);
         end else if (!req[1] && $urandom_range(0, 2) == 0) begin
            req[1] = 1'b1; code1 = 4'($urandom_range(0, 15)); line1 = 4'($urandom);
         end
      end
      req = 2'b00;
      idle(ROM_LAT + 4);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
